// File: rtl/island_sensor_pkg.sv
// Shared constants, vector type and counter-width helpers for the island idle sensor.
// Widths are computed from the instantiating module's parameters through these functions.
package island_sensor_pkg;

   localparam int N_SENSOR      = 10;
   localparam int WIN_LEN_DEF   = 256;
   localparam int ACT_THR_DEF   = 4;
   localparam int IDLE_WINS_DEF = 3;

   typedef logic [N_SENSOR-1:0] sensor_vec_t;

   // Window counter runs 0..win_len-1
   function automatic int wcnt_width(input int win_len);
      return (win_len > 1) ? $clog2(win_len) : 1;
   endfunction

   // Saturating counter that must hold 0..max_val
   function automatic int sat_width(input int max_val);
      return $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/island_sensor_channel.sv
// One island channel: per-window activity count, run of idle windows, idle flag and wake.
// Wake on activity bypasses the window boundary and beats a coinciding window close.
module island_sensor_channel
   import island_sensor_pkg::*;
#(
   parameter int ACT_THR   = ACT_THR_DEF,
   parameter int IDLE_WINS = IDLE_WINS_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic win_end,
   input  logic act_i,
   output logic idle_i
);

   localparam int AW = sat_width(ACT_THR);
   localparam int IW = sat_width(IDLE_WINS);
   localparam logic [AW-1:0] ACT_SAT   = AW'(ACT_THR);
   localparam logic [AW:0]   ACT_THR_X = (AW+1)'(ACT_THR);
   localparam logic [IW-1:0] IDLE_SAT  = IW'(IDLE_WINS);

   logic [AW-1:0] act_cnt_reg, act_cnt_next;
   logic [IW-1:0] idle_cnt_reg, idle_cnt_next;
   logic          idle_reg, idle_next;
   logic          busy, wake;

   always_comb begin
      wake = act_i && idle_reg;
      // Activity in the closing cycle still counts toward the closing window
      busy = ({1'b0, act_cnt_reg} + {{AW{1'b0}}, act_i}) >= ACT_THR_X;

      act_cnt_next = act_cnt_reg;
      if (!en || win_end) begin
         act_cnt_next = '0;
      end else if (act_i && (act_cnt_reg != ACT_SAT)) begin
         act_cnt_next = act_cnt_reg + AW'(1);
      end

      idle_cnt_next = idle_cnt_reg;
      idle_next     = idle_reg;
      if (wake) begin
         idle_cnt_next = '0;
         idle_next     = 1'b0;
      end else if (win_end) begin
         if (busy) begin
            idle_cnt_next = '0;
         end else if (idle_cnt_reg != IDLE_SAT) begin
            idle_cnt_next = idle_cnt_reg + IW'(1);
         end
         idle_next = (idle_cnt_next == IDLE_SAT);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         act_cnt_reg  <= '0;
         idle_cnt_reg <= '0;
         idle_reg     <= 1'b0;
      end else begin
         act_cnt_reg  <= act_cnt_next;
         idle_cnt_reg <= idle_cnt_next;
         idle_reg     <= idle_next;
      end
   end

   assign idle_i = idle_reg;

endmodule

// File: rtl/island_activity_sensor.sv
// Per-island idle sensors for the power-gating controller: shared sampling window,
// ten channel instances, freezable registered outputs and a change pulse.
module island_activity_sensor
   import island_sensor_pkg::*;
#(
   parameter int WIN_LEN   = WIN_LEN_DEF,
   parameter int ACT_THR   = ACT_THR_DEF,
   parameter int IDLE_WINS = IDLE_WINS_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic                freeze,
   input  logic [N_SENSOR-1:0] act,
   output logic                sensor0_level0,
   output logic                sensor1_level0,
   output logic                sensor2_level0,
   output logic                sensor3_level0,
   output logic                sensor4_level0,
   output logic                sensor5_level0,
   output logic                sensor6_level0,
   output logic                sensor7_level0,
   output logic                sensor8_level0,
   output logic                sensor9_level0,
   output logic                upd
);

   localparam int WW = wcnt_width(WIN_LEN);
   localparam logic [WW-1:0] WCNT_LAST = WW'(WIN_LEN - 1);

   logic [WW-1:0] wcnt_reg, wcnt_next;
   logic          win_end;
   sensor_vec_t   idle_vec;
   sensor_vec_t   sensor_reg, sensor_next;
   logic          upd_reg, upd_next;

   always_comb begin
      win_end = en && (wcnt_reg == WCNT_LAST);
      // Disabled monitoring parks the window at 0 so re-enable starts a fresh window
      if (!en || (wcnt_reg == WCNT_LAST)) begin
         wcnt_next = '0;
      end else begin
         wcnt_next = wcnt_reg + WW'(1);
      end
      sensor_next = freeze ? sensor_reg : idle_vec;
      upd_next    = (sensor_next != sensor_reg);
   end

   generate
      for (genvar gi = 0; gi < N_SENSOR; gi++) begin : g_chan
         island_sensor_channel #(
            .ACT_THR   (ACT_THR),
            .IDLE_WINS (IDLE_WINS)
         ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .en      (en),
            .win_end (win_end),
            .act_i   (act[gi]),
            .idle_i  (idle_vec[gi])
         );
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         wcnt_reg   <= '0;
         sensor_reg <= '0;
         upd_reg    <= 1'b0;
      end else begin
         wcnt_reg   <= wcnt_next;
         sensor_reg <= sensor_next;
         upd_reg    <= upd_next;
      end
   end

   assign sensor0_level0 = sensor_reg[0];
   assign sensor1_level0 = sensor_reg[1];
   assign sensor2_level0 = sensor_reg[2];
   assign sensor3_level0 = sensor_reg[3];
   assign sensor4_level0 = sensor_reg[4];
   assign sensor5_level0 = sensor_reg[5];
   assign sensor6_level0 = sensor_reg[6];
   assign sensor7_level0 = sensor_reg[7];
   assign sensor8_level0 = sensor_reg[8];
   assign sensor9_level0 = sensor_reg[9];
   assign upd            = upd_reg;

endmodule

// File: tb/tb_island_activity_sensor.sv
// Bench for island_activity_sensor: directed table, hand-written corner sequences and
// random traffic, all cross-checked every cycle against a window/run-length reference model.
module tb_island_activity_sensor;

   localparam int WIN_LEN   = 8;
   localparam int ACT_THR   = 2;
   localparam int IDLE_WINS = 2;

   logic       clk = 1'b0;
   logic       rst, en, freeze;
   logic [9:0] act;
   logic       s0, s1, s2, s3, s4, s5, s6, s7, s8, s9, upd;
   logic [9:0] sens;

   assign sens = {s9, s8, s7, s6, s5, s4, s3, s2, s1, s0};

   always #5 clk = ~clk;

   island_activity_sensor #(
      .WIN_LEN   (WIN_LEN),
      .ACT_THR   (ACT_THR),
      .IDLE_WINS (IDLE_WINS)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .en             (en),
      .freeze         (freeze),
      .act            (act),
      .sensor0_level0 (s0),
      .sensor1_level0 (s1),
      .sensor2_level0 (s2),
      .sensor3_level0 (s3),
      .sensor4_level0 (s4),
      .sensor5_level0 (s5),
      .sensor6_level0 (s6),
      .sensor7_level0 (s7),
      .sensor8_level0 (s8),
      .sensor9_level0 (s9),
      .upd            (upd)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int cyc_now  = 0;
   int next_cyc = 0;

   // Reference: position in window, unsaturated activity sum, unbounded idle-window run
   int         m_pos;
   int         m_sum [10];
   int         m_run [10];
   logic [9:0] m_sens;
   logic       m_upd;

   typedef struct {
      int         n;
      logic [9:0] a;
      logic [9:0] exp_s;
      logic       exp_u;
   } vec_t;

   vec_t tbl [16];

   function automatic logic [9:0] m_idle_vec();
      logic [9:0] v;
      for (int i = 0; i < 10; i++) v[i] = (m_run[i] >= IDLE_WINS);
      return v;
   endfunction

   task automatic model_step(input logic r, input logic e, input logic f, input logic [9:0] a);
      logic [9:0] nxt;
      bit         closing;
      if (r) begin
         m_pos  = 0;
         m_sens = '0;
         m_upd  = 1'b0;
         for (int i = 0; i < 10; i++) begin
            m_sum[i] = 0;
            m_run[i] = 0;
         end
         return;
      end
      nxt     = f ? m_sens : m_idle_vec();
      m_upd   = (nxt != m_sens);
      m_sens  = nxt;
      closing = e && (m_pos == WIN_LEN - 1);
      for (int i = 0; i < 10; i++) begin
         if (a[i] && (m_run[i] >= IDLE_WINS)) m_run[i] = 0;
         else if (closing) m_run[i] = ((m_sum[i] + int'(a[i])) >= ACT_THR) ? 0 : m_run[i] + 1;
         if (!e || closing) m_sum[i] = 0;
         else m_sum[i] = m_sum[i] + int'(a[i]);
      end
      m_pos = e ? (m_pos + 1) % WIN_LEN : 0;
   endtask

   task automatic check_val(input string name, input logic [9:0] got, input logic [9:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s cycle %0d: got %h, expected %h", name, cyc_now, got, want);
      end
   endtask

   // One clock cycle: drive inputs, compare outputs mid-cycle, advance the model
   task automatic step(input logic r, input logic e, input logic f, input logic [9:0] a,
                       input bit chk = 1'b0, input logic [9:0] exp_s = '0,
                       input logic exp_u = 1'b0, input string tag = "");
      rst = r; en = e; freeze = f; act = a;
      cyc_now = next_cyc;
      @(negedge clk);
      check_val("model_sensor", sens, m_sens);
      check_val("model_upd", {9'b0, upd}, {9'b0, m_upd});
      if (chk) begin
         check_val({tag, "_sensor"}, sens, exp_s);
         check_val({tag, "_upd"}, {9'b0, upd}, {9'b0, exp_u});
         $display("%s cycle %0d: act=%h sensor=%h upd=%b", tag, cyc_now, a, sens, upd);
      end
      model_step(r, e, f, a);
      next_cyc = r ? 0 : next_cyc + 1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic       r_en, r_frz;
      logic [9:0] r_act;

      rst = 1'b1; en = 1'b0; freeze = 1'b0; act = '0;
      repeat (2) @(posedge clk);
      #1;
      model_step(1'b1, 1'b0, 1'b0, '0);

      // Quiet start, wake on act[5], wake coinciding with window close on act[0]
      tbl[0]  = '{16, 10'h000, 10'h000, 1'b0};
      tbl[1]  = '{ 1, 10'h000, 10'h000, 1'b0};
      tbl[2]  = '{ 1, 10'h000, 10'h3FF, 1'b1};
      tbl[3]  = '{ 2, 10'h000, 10'h3FF, 1'b0};
      tbl[4]  = '{ 1, 10'h020, 10'h3FF, 1'b0};
      tbl[5]  = '{ 1, 10'h000, 10'h3FF, 1'b0};
      tbl[6]  = '{ 1, 10'h000, 10'h3DF, 1'b1};
      tbl[7]  = '{ 1, 10'h000, 10'h3DF, 1'b0};
      tbl[8]  = '{ 9, 10'h000, 10'h3DF, 1'b0};
      tbl[9]  = '{ 1, 10'h000, 10'h3FF, 1'b1};
      tbl[10] = '{ 5, 10'h000, 10'h3FF, 1'b0};
      tbl[11] = '{ 1, 10'h001, 10'h3FF, 1'b0};
      tbl[12] = '{ 1, 10'h000, 10'h3FF, 1'b0};
      tbl[13] = '{ 1, 10'h000, 10'h3FE, 1'b1};
      tbl[14] = '{15, 10'h000, 10'h3FE, 1'b0};
      tbl[15] = '{ 1, 10'h000, 10'h3FF, 1'b1};

      step(1'b1, 1'b1, 1'b0, '0, 1'b1, 10'h000, 1'b0, "reset");
      for (int v = 0; v < 16; v++) begin
         for (int k = 0; k < tbl[v].n; k++) begin
            step(1'b0, 1'b1, 1'b0, tbl[v].a, (k == tbl[v].n - 1), tbl[v].exp_s, tbl[v].exp_u,
                 $sformatf("tbl%0d", v));
         end
      end

      // One act[3] pulse per window stays below threshold
      step(1'b1, 1'b1, 1'b0, '0);
      for (int c = 0; c < 18; c++) begin
         step(1'b0, 1'b1, 1'b0, (c % 8 == 2) ? 10'h008 : 10'h000,
              (c >= 16), (c == 17) ? 10'h3FF : 10'h000, (c == 17), "one_per_win");
      end

      // Two act[3] pulses per window keep island 3 busy
      step(1'b1, 1'b1, 1'b0, '0);
      for (int c = 0; c < 40; c++) begin
         step(1'b0, 1'b1, 1'b0, ((c % 8 == 2) || (c % 8 == 5)) ? 10'h008 : 10'h000,
              (c == 17 || c == 39), 10'h3F7, (c == 17), "two_per_win");
      end

      // Freeze holds outputs across the assertion point
      step(1'b1, 1'b1, 1'b0, '0);
      for (int c = 0; c < 33; c++) begin
         step(1'b0, 1'b1, (c >= 10 && c <= 29), '0,
              (c == 17 || c >= 29), (c >= 31) ? 10'h3FF : 10'h000, (c == 31), "freeze");
      end

      // Reset mid-window restarts all timing
      step(1'b1, 1'b1, 1'b0, '0);
      for (int c = 0; c < 12; c++) step(1'b0, 1'b1, 1'b0, '0);
      step(1'b1, 1'b1, 1'b0, '0, 1'b1, 10'h000, 1'b0, "mid_rst");
      for (int c = 0; c < 18; c++) begin
         step(1'b0, 1'b1, 1'b0, '0, (c == 4 || c >= 16),
              (c == 17) ? 10'h3FF : 10'h000, (c == 17), "after_rst");
      end

      // en=0 parks the window; wake still works while disabled
      step(1'b1, 1'b1, 1'b0, '0);
      for (int c = 0; c < 41; c++) begin
         step(1'b0, (c >= 20 && c <= 37), 1'b0, (c == 38) ? 10'h004 : 10'h000,
              (c == 19 || c == 36 || c == 37 || c == 40),
              (c == 37) ? 10'h3FF : ((c == 40) ? 10'h3FB : 10'h000),
              (c == 37 || c == 40), "enable");
      end

      // Random traffic against the reference model
      step(1'b1, 1'b1, 1'b0, '0);
      r_en  = 1'b1;
      r_frz = 1'b0;
      for (int c = 0; c < 960; c++) begin
         if ($urandom_range(0, 19) == 0) r_en = ~r_en;
         if ($urandom_range(0, 24) == 0) r_frz = ~r_frz;
         for (int i = 0; i < 10; i++) r_act[i] = ($urandom_range(0, 99) < i * 3);
         step(($urandom_range(0, 299) == 0), r_en, r_frz, r_act);
         if (c % 64 == 63) begin
            $display("random block ending cycle %0d: sensor=%h model=%h", cyc_now, sens, m_sens);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
